// File: rtl/simultaneous_to_sequential_reg.sv
// -----------------------------------------------------------------------------
// simultaneous_to_sequential_reg
//
// Parallel-to-serial shift stage. One load captures SHIFT_LEN words of
// BIT_WIDTH bits. The stage then emits them one word per accepted handshake on
// a registered serial output. This feeds the word-serial chien/correction path
// from the parallel syndrome/error-locator stages. It is the inverse of
// sequentialToSimultaneousReg_psLast when both use the same DIRECTION and
// SHIFT_LEN.
//
// Parameters
//   DIRECTION  >0 emits slice SHIFT_LEN-1 first; <=0 emits slice 0 first
//   SHIFT_LEN  words per burst (>=1)
//   BIT_WIDTH  bits per word (>=1)
//
// Ports
//   clk                 rising-edge clock
//   in_ctr_Arst         asynchronous active-high reset
//   in_ctr_Srst         synchronous flush; abandons the current burst
//   in_ctr_load_valid   parallel vector offered on `in`
//   out_ctr_load_ready  stage accepts a vector this cycle (combinational)
//   in                  parallel vector, slice k = in[BIT_WIDTH*(k+1)-1 -: BIT_WIDTH]
//   out                 current serial word (registered)
//   out_ctr_valid       out holds a valid word
//   in_ctr_ready        downstream accepts out this cycle
//   out_ctr_first       out is the first word of a burst
//   out_ctr_last        out is the final word of a burst
//
// Optional feature macro: SIM_TO_SEQ_ZERO_IDLE_EN
//   When defined, out reads as zero whenever out_ctr_valid is low.
//   When undefined, out keeps the last emitted word while idle.
// -----------------------------------------------------------------------------
module simultaneous_to_sequential_reg #(
    parameter int DIRECTION = 1,
    parameter int SHIFT_LEN = 4,
    parameter int BIT_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           in_ctr_Arst,
    input  logic                           in_ctr_Srst,
    input  logic                           in_ctr_load_valid,
    output logic                           out_ctr_load_ready,
    input  logic [BIT_WIDTH*SHIFT_LEN-1:0] in,
    output logic [BIT_WIDTH-1:0]           out,
    output logic                           out_ctr_valid,
    input  logic                           in_ctr_ready,
    output logic                           out_ctr_first,
    output logic                           out_ctr_last
);

    localparam int VEC_W = BIT_WIDTH * SHIFT_LEN;
    localparam int CNT_W = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // The word to present next always sits at the "head" end of the vector.
    // The head end is selected by DIRECTION.
    function automatic logic [BIT_WIDTH-1:0] head_word(input logic [VEC_W-1:0] vec);
        if (DIRECTION > 0) begin
            return vec[VEC_W-1 -: BIT_WIDTH];
        end else begin
            return vec[BIT_WIDTH-1:0];
        end
    endfunction

    // Drop the head word so that the following slice moves to the head.
    function automatic logic [VEC_W-1:0] advance(input logic [VEC_W-1:0] vec);
        if (DIRECTION > 0) begin
            return vec << BIT_WIDTH;
        end else begin
            return vec >> BIT_WIDTH;
        end
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [VEC_W-1:0]     shreg_q, shreg_d;
    logic [BIT_WIDTH-1:0] out_q,   out_d;
    logic                 valid_q, valid_d;
    logic                 first_q, first_d;
    logic                 last_q,  last_d;

    logic                 load_s;
    logic                 move_s;
    logic [CNT_W-1:0]     count_inc_s;

    // Load acceptance: always in IDLE; in SHIFT only while the final word leaves.
    always_comb begin
        out_ctr_load_ready = 1'b0;
        case (state_q)
            ST_IDLE:  out_ctr_load_ready = 1'b1;
            ST_SHIFT: out_ctr_load_ready = last_q & in_ctr_ready;
            default:  out_ctr_load_ready = 1'b0;
        endcase
    end

    // Next-state logic. Flush beats load, and load beats word advance. A load
    // during the final handshake therefore restarts the burst without a bubble.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shreg_d     = shreg_q;
        out_d       = out_q;
        valid_d     = valid_q;
        first_d     = first_q;
        last_d      = last_q;
        load_s      = in_ctr_load_valid & out_ctr_load_ready;
        move_s      = valid_q & in_ctr_ready;
        count_inc_s = count_q + CNT_ONE;

        if (in_ctr_Srst) begin
            state_d = ST_IDLE;
            count_d = CNT_ZERO;
            shreg_d = {VEC_W{1'b0}};
            out_d   = {BIT_WIDTH{1'b0}};
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
        end else if (load_s) begin
            // The head word goes straight to out. The remainder stays queued in shreg.
            state_d = ST_SHIFT;
            count_d = CNT_ZERO;
            shreg_d = advance(in);
            out_d   = head_word(in);
            valid_d = 1'b1;
            first_d = 1'b1;
            last_d  = (CNT_LAST == CNT_ZERO);
        end else if (move_s) begin
            if (last_q) begin
                // out keeps the last word. Only the valid/flag bits drop.
                state_d = ST_IDLE;
                count_d = CNT_ZERO;
                valid_d = 1'b0;
                first_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                count_d = count_inc_s;
                shreg_d = advance(shreg_q);
                out_d   = head_word(shreg_q);
                first_d = 1'b0;
                last_d  = (count_inc_s == CNT_LAST);
            end
        end else begin
            // Stalled or idle: hold everything.
            state_d = state_q;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge in_ctr_Arst) begin
        if (in_ctr_Arst) begin
            state_q <= ST_IDLE;
            count_q <= CNT_ZERO;
            shreg_q <= {VEC_W{1'b0}};
            out_q   <= {BIT_WIDTH{1'b0}};
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign out_ctr_valid = valid_q;
    assign out_ctr_first = first_q;
    assign out_ctr_last  = last_q;

`ifdef SIM_TO_SEQ_ZERO_IDLE_EN
    assign out = valid_q ? out_q : {BIT_WIDTH{1'b0}};
`else
    assign out = out_q;
`endif

endmodule

// File: tb/tb_simultaneous_to_sequential_reg.sv
// -----------------------------------------------------------------------------
// Testbench for simultaneous_to_sequential_reg.
// Three instances share clock, resets and downstream ready:
//   u_fwd : DIRECTION=1, SHIFT_LEN=4, BIT_WIDTH=2
//   u_bwd : DIRECTION=0, SHIFT_LEN=4, BIT_WIDTH=2 (same stimulus as u_fwd)
//   u_one : DIRECTION=1, SHIFT_LEN=1, BIT_WIDTH=2
// Stimulus pushes the expected {word, first, last} into a per-instance queue.
// A negedge monitor pops an entry and compares it on every valid&ready cycle.
// -----------------------------------------------------------------------------
module tb_simultaneous_to_sequential_reg;

    logic       clk = 1'b0;
    logic       arst, srst, lv, rdy, o_lv;
    logic [7:0] din;
    logic [1:0] o_din;

    logic [1:0] f_out, b_out, o_out;
    logic       f_v, f_first, f_last, f_lr;
    logic       b_v, b_first, b_last, b_lr;
    logic       o_v, o_first, o_last, o_lr;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] qf[$];
    logic [3:0] qb[$];
    logic [3:0] qo[$];

    always #5 clk = ~clk;

    simultaneous_to_sequential_reg #(.DIRECTION(1), .SHIFT_LEN(4), .BIT_WIDTH(2)) u_fwd (
        .clk(clk), .in_ctr_Arst(arst), .in_ctr_Srst(srst), .in_ctr_load_valid(lv),
        .out_ctr_load_ready(f_lr), .in(din), .out(f_out), .out_ctr_valid(f_v),
        .in_ctr_ready(rdy), .out_ctr_first(f_first), .out_ctr_last(f_last));

    simultaneous_to_sequential_reg #(.DIRECTION(0), .SHIFT_LEN(4), .BIT_WIDTH(2)) u_bwd (
        .clk(clk), .in_ctr_Arst(arst), .in_ctr_Srst(srst), .in_ctr_load_valid(lv),
        .out_ctr_load_ready(b_lr), .in(din), .out(b_out), .out_ctr_valid(b_v),
        .in_ctr_ready(rdy), .out_ctr_first(b_first), .out_ctr_last(b_last));

    simultaneous_to_sequential_reg #(.DIRECTION(1), .SHIFT_LEN(1), .BIT_WIDTH(2)) u_one (
        .clk(clk), .in_ctr_Arst(arst), .in_ctr_Srst(srst), .in_ctr_load_valid(o_lv),
        .out_ctr_load_ready(o_lr), .in(o_din), .out(o_out), .out_ctr_valid(o_v),
        .in_ctr_ready(rdy), .out_ctr_first(o_first), .out_ctr_last(o_last));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every presented word that is accepted must match the queue head.
    always @(negedge clk) begin
        if (!arst) begin
            if (f_v && rdy) begin
                if (qf.size() == 0) chk("fwd_unexpected_word", 32'd1, 32'd0);
                else chk("fwd_word", {28'd0, f_out, f_first, f_last}, {28'd0, qf.pop_front()});
            end
            if (b_v && rdy) begin
                if (qb.size() == 0) chk("bwd_unexpected_word", 32'd1, 32'd0);
                else chk("bwd_word", {28'd0, b_out, b_first, b_last}, {28'd0, qb.pop_front()});
            end
            if (o_v && rdy) begin
                if (qo.size() == 0) chk("one_unexpected_word", 32'd1, 32'd0);
                else chk("one_word", {28'd0, o_out, o_first, o_last}, {28'd0, qo.pop_front()});
            end
        end
    end

    // Expected serial sequence of an 8-bit vector: {word, first, last} per entry.
    task automatic push_vec(input logic [7:0] v);
        for (int k = 0; k < 4; k++) begin
            qf.push_back({v[2*(3-k) +: 2], k == 0, k == 3});
            qb.push_back({v[2*k +: 2], k == 0, k == 3});
        end
    endtask

    initial begin
        arst = 1'b1; srst = 1'b0; lv = 1'b0; rdy = 1'b1; din = 8'h00;
        o_lv = 1'b0; o_din = 2'b00;
        #2;
        // Reset state.
        chk("rst_valid", {30'd0, f_v, b_v}, 32'd0);
        chk("rst_out", {28'd0, f_out, b_out}, 32'd0);
        chk("rst_flags", {28'd0, f_first, f_last, b_first, b_last}, 32'd0);
        chk("rst_load_ready", {29'd0, f_lr, b_lr, o_lr}, 32'd7);
        #5 arst = 1'b0;
        tick();

        // Single burst, forward and backward order.
        push_vec(8'hE4);
        lv = 1'b1; din = 8'hE4;
        tick();
        lv = 1'b0; din = 8'h00;
        chk("burst_lat_valid", {30'd0, f_v, b_v}, 32'd3);
        repeat (4) tick();
        chk("burst_end_valid", {30'd0, f_v, b_v}, 32'd0);
        chk("burst_end_ready", {30'd0, f_lr, b_lr}, 32'd3);
`ifdef SIM_TO_SEQ_ZERO_IDLE_EN
        chk("idle_out_bwd", {30'd0, b_out}, 32'd0);
`else
        chk("idle_out_bwd", {30'd0, b_out}, 32'd3);
`endif

        // Back-to-back bursts with load_valid held high.
        push_vec(8'hE4);
        push_vec(8'h1B);
        lv = 1'b1; din = 8'hE4;
        tick();
        din = 8'h1B;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_valid_a", {31'd0, f_v}, 32'd1);
            chk("b2b_load_ready", {31'd0, f_lr}, (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        lv = 1'b0; din = 8'h00;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_valid_b", {30'd0, f_v, b_v}, 32'd3);
            tick();
        end
        chk("b2b_end_valid", {30'd0, f_v, b_v}, 32'd0);

        // Backpressure after the second word. A load offered while stalled must be ignored.
        push_vec(8'hE4);
        lv = 1'b1; din = 8'hE4;
        tick();
        lv = 1'b0;
        tick();
        rdy = 1'b0; lv = 1'b1; din = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            chk("stall_out_fwd", {30'd0, f_out}, 32'd2);
            chk("stall_out_bwd", {30'd0, b_out}, 32'd1);
            chk("stall_load_ready", {30'd0, f_lr, b_lr}, 32'd0);
            tick();
        end
        lv = 1'b0; din = 8'h00; rdy = 1'b1;
        repeat (3) tick();
        chk("stall_end_valid", {30'd0, f_v, b_v}, 32'd0);

        // Flush with a simultaneous load after the first word.
        qf.push_back({2'd3, 1'b1, 1'b0}); qf.push_back({2'd2, 1'b0, 1'b0});
        qb.push_back({2'd0, 1'b1, 1'b0}); qb.push_back({2'd1, 1'b0, 1'b0});
        lv = 1'b1; din = 8'hE4;
        tick();
        lv = 1'b0;
        tick();
        srst = 1'b1; lv = 1'b1; din = 8'h1B;
        tick();
        srst = 1'b0; lv = 1'b0; din = 8'h00;
        chk("flush_valid", {30'd0, f_v, b_v}, 32'd0);
        chk("flush_ready", {30'd0, f_lr, b_lr}, 32'd3);
        chk("flush_out", {28'd0, f_out, b_out}, 32'd0);
        repeat (2) tick();
        chk("flush_no_emit", {30'd0, f_v, b_v}, 32'd0);

        // Asynchronous reset pulse between clock edges, mid-burst.
        qf.push_back({2'd3, 1'b1, 1'b0}); qf.push_back({2'd2, 1'b0, 1'b0});
        qb.push_back({2'd0, 1'b1, 1'b0}); qb.push_back({2'd1, 1'b0, 1'b0});
        lv = 1'b1; din = 8'hE4;
        tick();
        lv = 1'b0;
        tick();
        #6 arst = 1'b1;
        #1;
        chk("arst_valid", {30'd0, f_v, b_v}, 32'd0);
        chk("arst_out", {28'd0, f_out, b_out}, 32'd0);
        chk("arst_flags", {28'd0, f_first, f_last, b_first, b_last}, 32'd0);
        chk("arst_ready", {30'd0, f_lr, b_lr}, 32'd3);
        #1 arst = 1'b0;
        tick();
        chk("arst_after_valid", {30'd0, f_v, b_v}, 32'd0);
        chk("arst_after_ready", {30'd0, f_lr, b_lr}, 32'd3);

        // SHIFT_LEN=1: single word carries both flags, then back-to-back loads.
        qo.push_back({2'd2, 1'b1, 1'b1});
        o_lv = 1'b1; o_din = 2'b10;
        tick();
        o_lv = 1'b0; o_din = 2'b00;
        chk("one_valid", {31'd0, o_v}, 32'd1);
        tick();
        chk("one_idle_valid", {31'd0, o_v}, 32'd0);
`ifdef SIM_TO_SEQ_ZERO_IDLE_EN
        chk("one_idle_out", {30'd0, o_out}, 32'd0);
`else
        chk("one_idle_out", {30'd0, o_out}, 32'd2);
`endif
        qo.push_back({2'd1, 1'b1, 1'b1});
        qo.push_back({2'd3, 1'b1, 1'b1});
        o_lv = 1'b1; o_din = 2'b01;
        tick();
        chk("one_b2b_ready", {31'd0, o_lr}, 32'd1);
        o_din = 2'b11;
        tick();
        o_lv = 1'b0;
        chk("one_b2b_valid", {31'd0, o_v}, 32'd1);
        tick();

        chk("queues_drained", qf.size() + qb.size() + qo.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
